// File: rtl/shift_deser.sv
// shift_deser: serial-to-parallel receiver rebuilding WIDTH-bit words from SHIFT_AMOUNT-bit beats,
// delivered through a one-word valid/ready holding register with a sticky overrun flag.
module shift_deser #(
    parameter int WIDTH           = 8,
    parameter     SHIFT_DIRECTION = "RIGHT",
    parameter int SHIFT_AMOUNT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SHIFT_AMOUNT-1:0] si,
    input  logic                    si_valid,
    input  logic                    si_start,
    output logic [WIDTH-1:0]        po,
    output logic                    po_valid,
    input  logic                    po_ready,
    output logic                    busy,
    output logic                    overrun
);
    localparam int BEATS = WIDTH / SHIFT_AMOUNT;
    localparam int CW    = $clog2(BEATS) + 1;

    typedef enum logic {IDLE, RECV} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d, po_q, po_d, shifted;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic             po_valid_q, po_valid_d, overrun_q, overrun_d;
    logic             beat, complete, xfer;

    if (WIDTH == SHIFT_AMOUNT) begin : g_whole
        assign shifted = si;
    end else if (SHIFT_DIRECTION == "RIGHT") begin : g_right
        assign shifted = {si, sr_q[WIDTH-1:SHIFT_AMOUNT]};
    end else begin : g_left
        assign shifted = {sr_q[WIDTH-SHIFT_AMOUNT-1:0], si};
    end

    always_comb begin
        beat       = si_valid && (si_start || state_q == RECV);
        cnt_inc    = si_start ? CW'(1) : cnt_q + CW'(1);
        complete   = beat && cnt_inc == CW'(BEATS);
        xfer       = po_valid_q && po_ready;
        sr_d       = beat ? shifted : sr_q;
        cnt_d      = beat ? (complete ? '0 : cnt_inc) : cnt_q;
        state_d    = beat ? (complete ? IDLE : RECV) : state_q;
        // a completed word only lands if the holding register is empty or emptying this edge
        po_d       = (complete && (!po_valid_q || xfer)) ? shifted : po_q;
        po_valid_d = complete || (po_valid_q && !xfer);
        overrun_d  = overrun_q || (complete && po_valid_q && !xfer);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign po       = po_q;
    assign po_valid = po_valid_q;
    assign busy     = state_q == RECV;
    assign overrun  = overrun_q;
endmodule
